// File: rtl/cake_scheduler.sv
// Time-multiplexes N_CAKES renderers onto one VGA plot port, with a periodic shift round.
// Optional macro CAKE_SCHED_TIMEOUT_EN adds a per-cake wait timeout that skips a stuck renderer.
module cake_scheduler #(
  parameter int N_CAKES   = 4,
  parameter int SHIFT_DIV = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   enable,
  input  logic                   frame_tick,
  input  logic [N_CAKES-1:0]     done_in,
  input  logic [8*N_CAKES-1:0]   x_in,
  input  logic [7*N_CAKES-1:0]   y_in,
  input  logic [3*N_CAKES-1:0]   colour_in,
  output logic [N_CAKES-1:0]     go_cake,
  output logic [N_CAKES-1:0]     go_shift,
  output logic [7:0]             x_out,
  output logic [6:0]             y_out,
  output logic [2:0]             colour_out,
  output logic                   plot,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   overrun,
  output logic                   timeout_err
);

  localparam int IW = (N_CAKES > 1) ? $clog2(N_CAKES) : 1;
  localparam logic [N_CAKES-1:0] ONE_HOT0 = N_CAKES'(1);
  localparam logic [IW-1:0]      IDX_ONE  = IW'(1);
  localparam logic [IW-1:0]      IDX_LAST = IW'(N_CAKES - 1);
  localparam logic [3:0]         CNT_LAST = 4'(SHIFT_DIV - 1);

  // State is left as a plain named register so checkers can bind to it.
  typedef enum logic [2:0] {S_IDLE, S_GO, S_WAIT, S_NEXT, S_SHIFT} state_t;
  state_t        state;
  logic [IW-1:0] index;
  logic [IW-1:0] next_index;
  logic [3:0]    frame_cnt;
  logic          last;
  logic          done_sel;
  logic [7:0]    x_sel;
  logic [6:0]    y_sel;
  logic [2:0]    colour_sel;

  always_comb begin
    done_sel   = 1'b0;
    x_sel      = '0;
    y_sel      = '0;
    colour_sel = '0;
    for (int i = 0; i < N_CAKES; i++) begin
      if (index == IW'(i)) begin
        done_sel   = done_in[i];
        x_sel      = x_in[8*i +: 8];
        y_sel      = y_in[7*i +: 7];
        colour_sel = colour_in[3*i +: 3];
      end
    end
  end

  assign next_index = index + IDX_ONE;
  assign last       = (index == IDX_LAST);
  assign busy       = (state != S_IDLE);
  // Pixel data is only passed through while the selected renderer is drawing.
  assign x_out      = (state == S_WAIT) ? x_sel      : '0;
  assign y_out      = (state == S_WAIT) ? y_sel      : '0;
  assign colour_out = (state == S_WAIT) ? colour_sel : '0;

`ifdef CAKE_SCHED_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       timeout_err_q;
  assign timeout_err = timeout_err_q;
`else
  logic [7:0] timeout_unused;
  assign timeout_unused = 8'(TIMEOUT);
  assign timeout_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      index      <= '0;
      frame_cnt  <= '0;
      go_cake    <= '0;
      go_shift   <= '0;
      plot       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
`ifdef CAKE_SCHED_TIMEOUT_EN
      wait_cnt      <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      go_cake    <= '0;
      go_shift   <= '0;
      frame_done <= 1'b0;
      if (frame_tick && state != S_IDLE) overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          if (frame_tick && enable) begin
            state   <= S_GO;
            index   <= '0;
            go_cake <= ONE_HOT0;
          end
        end
        S_GO: begin
          state <= S_WAIT;
          plot  <= 1'b1;
`ifdef CAKE_SCHED_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        S_WAIT: begin
`ifdef CAKE_SCHED_TIMEOUT_EN
          if (done_sel || wait_cnt == 8'(TIMEOUT)) begin
            if (!done_sel) timeout_err_q <= 1'b1;
            state      <= S_NEXT;
            plot       <= 1'b0;
            frame_done <= last;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`else
          if (done_sel) begin
            state      <= S_NEXT;
            plot       <= 1'b0;
            frame_done <= last;
          end
`endif
        end
        S_NEXT: begin
          if (!last) begin
            index   <= next_index;
            state   <= S_GO;
            go_cake <= ONE_HOT0 << next_index;
          end else if (frame_cnt == CNT_LAST) begin
            frame_cnt <= '0;
            index     <= '0;
            state     <= S_SHIFT;
            go_shift  <= ONE_HOT0;
          end else begin
            frame_cnt <= frame_cnt + 4'd1;
            index     <= '0;
            state     <= S_IDLE;
          end
        end
        S_SHIFT: begin
          if (last) begin
            state <= S_IDLE;
            index <= '0;
          end else begin
            index    <= next_index;
            go_shift <= ONE_HOT0 << next_index;
          end
        end
        default: begin
          state <= S_IDLE;
          index <= '0;
          plot  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/cake_scheduler.md
Name: cake_scheduler

Overview:
Time-multiplexes N cake renderers onto the single VGA plot port (x, y, colour, plot).
- Each frame tick, starts the renderers one at a time in index order (go_cake) and forwards the active renderer's pixel stream while it draws.
- After SHIFT_DIV frames, issues go_shift to every renderer in order so each cake advances one row.
- Sits between the per-cake renderers and the VGA adapter.

Parameters:
N_CAKES, 4, number of renderer slots (1..8).
SHIFT_DIV, 4, frames drawn between shift rounds (1..15).
TIMEOUT, 255, max cycles to wait for done_in per cake (used only with CAKE_SCHED_TIMEOUT_EN).

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
enable  in  1  scheduling enabled
frame_tick  in  1  one-cycle frame strobe
done_in  in  N_CAKES  per-cake done_cake
x_in  in  8*N_CAKES  packed per-cake x; slot i at [8i+7:8i]
y_in  in  7*N_CAKES  packed per-cake y
colour_in  in  3*N_CAKES  packed per-cake colour
go_cake  out  N_CAKES  one-hot start pulse
go_shift  out  N_CAKES  one-hot shift pulse
x_out  out  8  plot x
y_out  out  7  plot y
colour_out  out  3  plot colour
plot  out  1  VGA write enable
busy  out  1  high in every state except S_IDLE
frame_done  out  1  one-cycle pulse after last cake drawn
overrun  out  1  sticky: frame_tick arrived while busy
timeout_err  out  1  sticky: cake skipped on timeout (0 if macro off)

Behaviour:
- Clock and reset: one clock, clk. Reset resetn is asynchronous, active-low.
- Reset values: state S_IDLE; index 0; frame counter 0; all outputs 0.
- Reset mid-operation: aborts immediately. Renderers get no further pulses.
- States:
  - S_IDLE: on (frame_tick & enable) → S_GO, index=0.
  - S_GO: go_cake[index]=1 for exactly one cycle → S_WAIT.
  - S_WAIT:
    - plot=1.
    - x_out/y_out/colour_out combinationally select slice [index] of x_in/y_in/colour_in.
    - On done_in[index]=1 → S_NEXT (plot still 1 that cycle).
  - S_NEXT:
    - plot=0.
    - If index<N_CAKES-1: index+1 → S_GO.
    - Else: frame_done=1; frame counter +1.
      - If counter reaches SHIFT_DIV: counter=0, index=0 → S_SHIFT.
      - Otherwise → S_IDLE.
  - S_SHIFT:
    - go_shift[index]=1 for one cycle; plot=0.
    - index+1 each cycle. After slot N_CAKES-1 → S_IDLE, index=0.
- Frame counter: 4-bit. Wraps to 0 exactly at SHIFT_DIV.
- Outside S_WAIT: x_out/y_out/colour_out hold 0.
- frame_tick while busy: ignored (no queueing); sets overrun. overrun clears only on reset.
- enable low mid-frame: current frame and any pending shift round complete; no new frame starts until enable is high at a frame_tick.
- done_in of non-selected slots: ignored.
- done_in[index] already high on entry to S_WAIT: advances on the first S_WAIT cycle.
- Frame latency: N_CAKES×(2+draw cycles) + 1 cycles from tick to frame_done.
- go_cake and go_shift are never high in the same cycle.

Optional Feature:
CAKE_SCHED_TIMEOUT_EN.
- Defined: an 8-bit wait counter clears on S_GO and increments in S_WAIT. When it equals TIMEOUT without done_in[index] → S_NEXT, set timeout_err (sticky).
- Undefined: S_WAIT waits indefinitely; timeout_err tied 0.

Test Plan:
- N_CAKES=4, SHIFT_DIV=2; models assert done 97 cycles after go; one frame_tick → go_cake pulses 0001,0010,0100,1000 in order; plot high 4×97 cycles; one frame_done; no go_shift.
- Second frame_tick after frame_done → after frame_done, go_shift 0001..1000 on 4 consecutive cycles; frame counter back to 0; busy drops.
- Slot 2 drives x=0x50,y=0x21,colour=5 → x_out/y_out/colour_out equal those values only while index=2 in S_WAIT; 0 outside S_WAIT.
- frame_tick during S_WAIT → overrun=1 and stays 1; no extra frame drawn.
- Assert resetn=0 mid-S_WAIT → all outputs 0 without a clock edge; after release, idle until next tick.
- With CAKE_SCHED_TIMEOUT_EN, TIMEOUT=20, slot 1 never done → slot 1 skipped after 20 cycles; go_cake[2] follows; timeout_err=1.
